// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and constants for the RSA host sequencer
package rsa_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    LOAD_N,
    LOAD_E,
    LOAD_M,
    START,
    WAIT,
    RD_ADDR,
    RD_CAP,
    SEND,
    ERR
  } state_e;

  localparam logic [1:0] REG_SEL_RES = 2'd0;
  localparam logic [1:0] REG_SEL_M   = 2'd1;
  localparam logic [1:0] REG_SEL_E   = 2'd2;
  localparam logic [1:0] REG_SEL_N   = 2'd3;

  localparam int         NBYTES_DEFAULT = 32;
  localparam logic [7:0] ERR_BYTE       = 8'hEE;

  // Core register addressed while the sequencer sits in a given state
  function automatic logic [1:0] reg_sel_of(state_e s);
    case (s)
      LOAD_N:  return REG_SEL_N;
      LOAD_E:  return REG_SEL_E;
      LOAD_M:  return REG_SEL_M;
      default: return REG_SEL_RES;
    endcase
  endfunction

endpackage

// File: rtl/rsa_timeout_cnt.sv
// rtl/rsa_timeout_cnt.sv - saturating cycle counter bounding the wait for core completion
module rsa_timeout_cnt #(
  parameter int TIMEOUT = 1048576,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          enable_i,
  output logic [CW-1:0] count_o,
  output logic          expired_o
);

  logic [CW-1:0] count_q;

  assign count_o   = count_q;
  assign expired_o = (count_q == CW'(TIMEOUT));

  // Count enabled cycles, holding at TIMEOUT so expiry stays asserted
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      count_q <= '0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/rsa_host_seq.sv
// rtl/rsa_host_seq.sv - byte-stream host sequencer loading operands into an RSA core and returning the result
module rsa_host_seq
  import rsa_pkg::*;
#(
  parameter int NBYTES  = NBYTES_DEFAULT,
  parameter int TIMEOUT = 1048576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       core_we_n,
  output logic       core_oe_n,
  output logic       core_start_n,
  output logic [1:0] core_reg_sel,
  output logic [4:0] core_addr,
  output logic [7:0] core_wdata,
  input  logic [7:0] core_rdata,
  input  logic       core_ready,
  output logic       busy
);

  localparam int         CW       = $clog2(TIMEOUT + 1);
  localparam logic [4:0] ADDR_TOP = 5'(NBYTES - 1);

  state_e        state_q, state_d;
  logic [4:0]    addr_q, addr_d;
  logic          reload_e_q, reload_e_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          rx_ready_q;
  logic          tx_valid_q;
  logic          core_oe_n_q;
  logic          core_start_n_q;
  logic          busy_q;
  logic [1:0]    reg_sel_q;

  logic          in_load;
  logic          rx_fire;
  logic          tx_fire;
  logic [CW-1:0] wait_count;
  logic          wait_expired;

  assign in_load = (state_q == LOAD_N) || (state_q == LOAD_E) || (state_q == LOAD_M);
  assign rx_fire = rx_valid && rx_ready_q;
  assign tx_fire = tx_valid_q && tx_ready;

  rsa_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_q == START),
    .enable_i  (state_q == WAIT),
    .count_o   (wait_count),
    .expired_o (wait_expired)
  );

  // The write strobe must coincide with the accepted byte, so it is the only strobe decoded from the handshake
  assign core_we_n    = !(in_load && rx_fire);
  assign core_wdata   = in_load ? rx_data : 8'h00;
  assign core_addr    = addr_q;
  assign core_reg_sel = reg_sel_q;
  assign core_oe_n    = core_oe_n_q;
  assign core_start_n = core_start_n_q;
  assign rx_ready     = rx_ready_q;
  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_data_q;
  assign busy         = busy_q;

  // Next-state, address walk and holding-register update
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    reload_e_d = reload_e_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: state_d = CMD;
      CMD: begin
        if (rx_fire) begin
          reload_e_d = rx_data[1];
          addr_d     = ADDR_TOP;
          if (rx_data[0])      state_d = LOAD_N;
          else if (rx_data[1]) state_d = LOAD_E;
          else                 state_d = LOAD_M;
        end
      end
      LOAD_N, LOAD_E, LOAD_M: begin
        if (rx_fire) begin
          if (addr_q == 5'd0) begin
            // Re-arm the address for the next operand, or for the result read-out after M
            addr_d = ADDR_TOP;
            if (state_q == LOAD_N)      state_d = reload_e_q ? LOAD_E : LOAD_M;
            else if (state_q == LOAD_E) state_d = LOAD_M;
            else                        state_d = START;
          end else begin
            addr_d = addr_q - 5'd1;
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // core_ready may still be stale from the previous run during the first two cycles
        if ((wait_count >= CW'(2)) && core_ready) begin
          state_d = RD_ADDR;
        end else if (wait_expired) begin
          state_d   = ERR;
          tx_data_d = ERR_BYTE;
        end
      end
      RD_ADDR: state_d = RD_CAP;
      RD_CAP: begin
        tx_data_d = core_rdata;
        state_d   = SEND;
      end
      SEND: begin
        if (tx_fire) begin
          if (addr_q == 5'd0) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q - 5'd1;
            state_d = RD_ADDR;
          end
        end
      end
      ERR: begin
        if (tx_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with outputs registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= 5'd0;
      reload_e_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      rx_ready_q     <= 1'b0;
      tx_valid_q     <= 1'b0;
      core_oe_n_q    <= 1'b1;
      core_start_n_q <= 1'b1;
      busy_q         <= 1'b0;
      reg_sel_q      <= REG_SEL_RES;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      reload_e_q     <= reload_e_d;
      tx_data_q      <= tx_data_d;
      rx_ready_q     <= (state_d inside {CMD, LOAD_N, LOAD_E, LOAD_M});
      tx_valid_q     <= (state_d inside {SEND, ERR});
      core_oe_n_q    <= (state_d != RD_ADDR);
      core_start_n_q <= (state_d != START);
      busy_q         <= (state_d != IDLE);
      reg_sel_q      <= reg_sel_of(state_d);
    end
  end

endmodule

// File: doc/rsa_host_seq.md
RSA_HOST_SEQ -- requirements
Module: rsa_host_seq

Interface
REQ-001 Parameter NBYTES, default 32, operand width in bytes (core operands 256 bit).
REQ-002 Parameter TIMEOUT, default 1048576, maximum cycles to wait for core completion.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_valid  in  1  host byte available.
REQ-006 rx_data  in  8  host byte.
REQ-007 rx_ready  out  1  block accepts rx_data; transfer when rx_valid & rx_ready.
REQ-008 tx_valid  out  1  result/status byte available.
REQ-009 tx_data  out  8  result/status byte.
REQ-010 tx_ready  in  1  host accepts tx_data; transfer when tx_valid & tx_ready.
REQ-011 core_we_n  out  1  core write strobe, active-low.
REQ-012 core_oe_n  out  1  core read strobe, active-low.
REQ-013 core_start_n  out  1  core start pulse, active-low, one cycle.
REQ-014 core_reg_sel  out  2  core register: 3=modulus N, 2=exponent E, 1=base M, 0=result.
REQ-015 core_addr  out  5  core byte address, 0 = least significant byte.
REQ-016 core_wdata  out  8  byte written to core.
REQ-017 core_rdata  in  8  core read byte, valid one cycle after core_oe_n low with addr.
REQ-018 core_ready  in  1  core result valid.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 States: IDLE, CMD, LOAD_N, LOAD_E, LOAD_M, START, WAIT, RD_ADDR, RD_CAP, SEND, ERR.
REQ-021 IDLE -> CMD immediately; CMD accepts one command byte; bit0=1 reload N, bit1=1 reload E, bits 7:2 ignored.
REQ-022 After CMD: LOAD_N if bit0, else LOAD_E if bit1, else LOAD_M; LOAD_N -> LOAD_E (if bit1) else LOAD_M; LOAD_E -> LOAD_M.
REQ-023 LOAD_x: rx_ready=1; each accepted byte written same cycle (core_we_n=0, reg_sel per REQ-014, core_wdata=rx_data); bytes arrive MSB first, addr NBYTES-1 down to 0.
REQ-024 LOAD_x leaves after byte at addr 0; rx_valid low stalls without write; core_we_n=1 on non-transfer cycles.
REQ-025 START: core_start_n=0 exactly one cycle, -> WAIT; timeout counter cleared.
REQ-026 WAIT: core_ready ignored first 2 cycles; then core_ready=1 -> RD_ADDR; counter reaching TIMEOUT first -> ERR.
REQ-027 RD_ADDR: core_oe_n=0, reg_sel=0, addr=NBYTES-1 down to 0; RD_CAP captures core_rdata next cycle into 8-bit holding register; -> SEND.
REQ-028 SEND: tx_valid=1, tx_data=holding register; held stable until tx_ready; after addr 0 byte -> IDLE, else -> RD_ADDR with addr-1.
REQ-029 Result streamed MSB first, NBYTES bytes; one byte per 3 cycles minimum.
REQ-030 ERR: tx_valid=1, tx_data=8'hEE until accepted, then -> IDLE; no result bytes sent.
REQ-031 N/E not reloaded retain prior core contents; block keeps no operand copy.
REQ-032 rx_ready=0 outside CMD/LOAD_x; tx_valid=0 outside SEND/ERR; core_we_n and core_oe_n never low same cycle.
REQ-033 Address counter 5 bits, decrements, wrap 0->31 never used as write address.

Reset
REQ-034 reset=1 at any cycle, mid-load or mid-read: next state IDLE, counters 0, addr 0, reg_sel 0.
REQ-035 Reset outputs: rx_ready=0, tx_valid=0, tx_data=0, core_we_n=1, core_oe_n=1, core_start_n=1, core_wdata=0, busy=0.
REQ-036 Partial transfers aborted; host restarts with command byte.

Structure
REQ-037 Shared package rsa_pkg: state enum, REG_SEL_RES/M/E/N constants, NBYTES default, ERR_BYTE=8'hEE.
REQ-038 Single module plus one sub-module rsa_timeout_cnt (clear, enable, expired at TIMEOUT).

Verification
REQ-039 Cmd 8'h03, N=0xBB, E=0x11, M=0x02 (32 bytes each), core model ready after 100 cycles -> 96 writes, reg_sel 3/2/1, addr 31..0, one start pulse, 32 result bytes MSB first.
REQ-040 Cmd 8'h00 then 32 M bytes -> only reg_sel=1 writes, N/E untouched, result returned.
REQ-041 rx_valid toggled every other cycle, tx_ready low 5 cycles per byte -> no lost/duplicate bytes, tx_data stable while stalled.
REQ-042 Core never asserts ready, TIMEOUT=64 -> exactly one 8'hEE byte, busy=0 after.
REQ-043 reset pulsed after 10 LOAD_E bytes -> outputs per REQ-035 next cycle; new full frame completes correctly.
REQ-044 core_ready high already during START -> ignored 2 cycles, then read proceeds; first read addr=31.
